// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Up-counter that saturates at all-ones; clear takes priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory
// freeze, mispredict squash, halt, plus stall/flush counters and memory timeout.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_mem_read,
    input  logic             EX_mispredict,
    input  logic             MEM_mem_req,
    input  logic             MEM_mem_ready,
    input  logic             WB_halt,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic             is_halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    // Last count value before the counter reaches WAIT_MAX on the next edge.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_t state, next_state;
    logic   load_use, mem_busy, misp_take;
    logic   stall_inc, wait_inc, wait_clear, timeout_set;
    logic [WAIT_W-1:0] wait_cnt;

    assign load_use = EX_mem_read && (EX_rd != ZERO_REG) &&
                      ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                       (ID_use_rs2 && (ID_rs2 == EX_rd)));
    assign mem_busy = MEM_mem_req && !MEM_mem_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state   = state;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        MEM_WB_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        misp_take    = 1'b0;

        if (state == HALTED || WB_halt) begin
            {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = '0;
            next_state = HALTED;
        end else if (mem_busy) begin
            {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = '0;
            MEM_WB_flush = 1'b1;
            next_state   = MEM_WAIT;
        end else begin
            next_state = RUN;
            // The squashed ID instruction cannot cause a load-use stall.
            if (EX_mispredict) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                misp_take   = 1'b1;
            end else if (load_use) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign is_halted = (state == HALTED);

    assign wait_inc    = (state == MEM_WAIT);
    assign wait_clear  = (next_state != MEM_WAIT);
    assign timeout_set = (state == MEM_WAIT) && (next_state == MEM_WAIT) &&
                         (wait_cnt >= WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_timeout <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout <= 1'b1;
        end
    end

    assign stall_inc = !PC_write && (state != HALTED);

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (wait_inc),
        .clear  (wait_clear),
        .count  (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (stall_inc),
        .clear  (1'b0),
        .count  (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (misp_take),
        .clear  (1'b0),
        .count  (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller (CNT_W=4, WAIT_MAX=3).
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;
    localparam int WAIT_MAX = 3;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, MEM_WB flushes}
    localparam logic [7:0] C_RUN = 8'b11111_000;
    localparam logic [7:0] C_FRZ = 8'b00000_001;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_MIS = 8'b11111_110;
    localparam logic [7:0] C_HLT = 8'b00000_000;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_use_rs1, ID_use_rs2, EX_mem_read, EX_mispredict;
    logic MEM_mem_req, MEM_mem_ready, WB_halt;
    logic PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic IF_ID_flush, ID_EX_flush, MEM_WB_flush, is_halted, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];
    string      tag_q[$];

    pipeline_hazard_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ID_rs1       (ID_rs1),
        .ID_rs2       (ID_rs2),
        .ID_use_rs1   (ID_use_rs1),
        .ID_use_rs2   (ID_use_rs2),
        .EX_rd        (EX_rd),
        .EX_mem_read  (EX_mem_read),
        .EX_mispredict(EX_mispredict),
        .MEM_mem_req  (MEM_mem_req),
        .MEM_mem_ready(MEM_mem_ready),
        .WB_halt      (WB_halt),
        .PC_write     (PC_write),
        .IF_ID_write  (IF_ID_write),
        .ID_EX_write  (ID_EX_write),
        .EX_MEM_write (EX_MEM_write),
        .MEM_WB_write (MEM_WB_write),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_flush  (ID_EX_flush),
        .MEM_WB_flush (MEM_WB_flush),
        .is_halted    (is_halted),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] ev(input logic [7:0] c, input logic h, input logic t);
        return {c, h, t};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
                IF_ID_flush, ID_EX_flush, MEM_WB_flush, is_halted, mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
        ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; EX_mem_read = 1'b0; EX_mispredict = 1'b0;
        MEM_mem_req = 1'b0; MEM_mem_ready = 1'b0; WB_halt = 1'b0;
    endtask

    // Called just after a rising edge with inputs applied; compares at the falling edge.
    task automatic step(input logic [9:0] expected, input string tag);
        logic [9:0] e;
        string      t;
        exp_q.push_back(expected);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(obs_vec()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int stalls, input int flushes);
        check({tag, "_stall"}, 32'(stall_count), 32'(stalls));
        check({tag, "_flush"}, 32'(flush_count), 32'(flushes));
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'(obs_vec()), 32'(ev(C_RUN, 1'b0, 1'b0)));
        check_cnt("rst", 0, 0);
        reset_n = 1'b1;

        // Loads to x0 and unused operands never stall.
        idle(); EX_mem_read = 1'b1; EX_rd = 5'd0; ID_use_rs1 = 1'b1; ID_use_rs2 = 1'b1;
        step(ev(C_RUN, 1'b0, 1'b0), "ld_x0");
        idle(); EX_mem_read = 1'b1; EX_rd = 5'd7; ID_use_rs1 = 1'b1; ID_rs1 = 5'd3; ID_rs2 = 5'd7;
        step(ev(C_RUN, 1'b0, 1'b0), "no_use_rs2");
        check_cnt("no_hazard", 0, 0);

        // Load-use on rs1: one bubble, then the bubble sits in EX.
        idle(); EX_mem_read = 1'b1; EX_rd = 5'd5; ID_use_rs1 = 1'b1; ID_rs1 = 5'd5;
        ID_use_rs2 = 1'b1; ID_rs2 = 5'd6;
        step(ev(C_LU, 1'b0, 1'b0), "lu_rs1");
        idle(); ID_use_rs1 = 1'b1; ID_rs1 = 5'd5;
        step(ev(C_RUN, 1'b0, 1'b0), "lu_after");
        check_cnt("lu1", 1, 0);

        idle(); EX_mem_read = 1'b1; EX_rd = 5'd7; ID_use_rs2 = 1'b1; ID_rs2 = 5'd7;
        step(ev(C_LU, 1'b0, 1'b0), "lu_rs2");
        check_cnt("lu2", 2, 0);

        // Short miss: wait counter must be cleared afterwards.
        idle(); MEM_mem_req = 1'b1;
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_s0");
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_s1");
        MEM_mem_ready = 1'b1;
        step(ev(C_RUN, 1'b0, 1'b0), "miss_s_rdy");
        check_cnt("miss_s", 4, 0);

        // Long miss: 4 frozen cycles, timeout after the 3rd MEM_WAIT cycle.
        idle(); MEM_mem_req = 1'b1;
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_run");
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_w1");
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_w2");
        step(ev(C_FRZ, 1'b0, 1'b0), "miss_w3");
        check_cnt("miss_l", 8, 0);
        MEM_mem_ready = 1'b1;
        step(ev(C_RUN, 1'b0, 1'b1), "miss_rdy");
        idle();
        step(ev(C_RUN, 1'b0, 1'b1), "timeout_sticky");

        // Mispredict beats load-use.
        idle(); EX_mispredict = 1'b1; EX_mem_read = 1'b1; EX_rd = 5'd5; ID_use_rs1 = 1'b1; ID_rs1 = 5'd5;
        step(ev(C_MIS, 1'b0, 1'b1), "mis_lu");
        check_cnt("mis_lu", 8, 1);

        // Mispredict under a freeze fires on the ready cycle.
        idle(); EX_mispredict = 1'b1; MEM_mem_req = 1'b1;
        step(ev(C_FRZ, 1'b0, 1'b1), "mis_frz0");
        step(ev(C_FRZ, 1'b0, 1'b1), "mis_frz1");
        MEM_mem_ready = 1'b1;
        step(ev(C_MIS, 1'b0, 1'b1), "mis_rdy");
        check_cnt("mis_frz", 10, 2);

        // Stall counter saturates at all-ones.
        idle(); MEM_mem_req = 1'b1;
        for (int i = 0; i < 8; i++) step(ev(C_FRZ, 1'b0, 1'b1), "sat_frz");
        MEM_mem_ready = 1'b1;
        step(ev(C_RUN, 1'b0, 1'b1), "sat_rdy");
        check_cnt("sat", 15, 2);

        // Asynchronous reset away from any clock edge.
        idle();
        #2 reset_n = 1'b0;
        #1;
        check("arst_ctl", 32'(obs_vec()), 32'(ev(C_RUN, 1'b0, 1'b0)));
        check_cnt("arst", 0, 0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Halt wins over mem_busy and mispredict.
        idle(); WB_halt = 1'b1; MEM_mem_req = 1'b1; EX_mispredict = 1'b1;
        step(ev(C_HLT, 1'b0, 1'b0), "halt_det");
        idle(); EX_mispredict = 1'b1; EX_mem_read = 1'b1; EX_rd = 5'd9; ID_use_rs1 = 1'b1; ID_rs1 = 5'd9;
        for (int i = 0; i < 10; i++) step(ev(C_HLT, 1'b1, 1'b0), "halted");
        check_cnt("halt", 1, 0);

        // Reset while halted returns to RUN at once.
        idle();
        #2 reset_n = 1'b0;
        #1;
        check("rst_halt_ctl", 32'(obs_vec()), 32'(ev(C_RUN, 1'b0, 1'b0)));
        check_cnt("rst_halt", 0, 0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(ev(C_RUN, 1'b0, 1'b0), "post_rst");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
